// File: rtl/io_input_fifo.sv
// Host-to-CPU input FIFO on the IO bus: host pushes bytes, CPU pops DATA and polls/writes STATUS.
// Optional IO_INPUT_IRQ_EN adds a registered irq output (!empty || overflow).
module io_input_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire  [7:0] io_bus,
  input  logic       seln,
  input  logic       rs,
  input  logic       from_devn,
  input  logic       to_devn,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
`ifdef IO_INPUT_IRQ_EN
  output logic       rx_full,
  output logic       irq
`else
  output logic       rx_full
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  full_q;

  logic rd, wr, drive_en, full, empty;
  logic pop, push, flush, ovf_set, ovf_clr;
  logic [7:0] rd_data;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  assign rd = !seln && !from_devn;
  assign wr = !seln && !to_devn && rs;
  // Bus is released during reset and when a read collides with a write strobe.
  assign drive_en = rd && to_devn && !reset;

  always_comb begin
    rd_data = '0;
    if (rs)
      rd_data = {5'b0, ovf_q, full, !empty};
    else if (!empty)
      rd_data = mem_q[rd_ptr_q];
  end

  assign io_bus = drive_en ? rd_data : 'z;

  assign flush   = wr && io_bus[0];
  assign ovf_clr = wr && io_bus[2];
  assign pop     = drive_en && !rs && !empty;
  // Fullness is judged before any same-cycle pop; a flush swallows the pushed byte.
  assign push    = rx_strobe && !full && !flush;
  assign ovf_set = rx_strobe && full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)
        count_d = count_q + 1'b1;
      else if (pop && !push)
        count_d = count_q - 1'b1;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
    end
  end

  assign rx_full = full_q;

`ifdef IO_INPUT_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= (count_d != '0) || ovf_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_io_input_fifo.sv
// Directed bench for io_input_fifo: bus reads/writes, host pushes, overflow, flush and reset cases.
// A weak pull-up on io_bus makes a released bus read as 8'hFF.
module tb_io_input_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       seln, rs, from_devn, to_devn;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic       rx_full;
  logic       cpu_oe;
  logic [7:0] cpu_drv;
  wire  [7:0] io_bus;
`ifdef IO_INPUT_IRQ_EN
  logic       irq;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  assign io_bus = cpu_oe ? cpu_drv : 'z;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (io_bus[g]);
  end

  io_input_fifo #(.DEPTH_LOG2(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .io_bus    (io_bus),
    .seln      (seln),
    .rs        (rs),
    .from_devn (from_devn),
    .to_devn   (to_devn),
    .rx_data   (rx_data),
    .rx_strobe (rx_strobe),
`ifdef IO_INPUT_IRQ_EN
    .rx_full   (rx_full),
    .irq       (irq)
`else
    .rx_full   (rx_full)
`endif
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    seln = 1'b1; rs = 1'b0; from_devn = 1'b1; to_devn = 1'b1;
    rx_strobe = 1'b0; rx_data = '0; cpu_oe = 1'b0; cpu_drv = '0;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1 idle();
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    rx_strobe = 1'b1; rx_data = b;
    finish_cycle();
  endtask

  task automatic read(input logic rsv, input logic [7:0] exp, input string tag);
    @(negedge clk);
    seln = 1'b0; from_devn = 1'b0; rs = rsv;
    #1 check(tag, io_bus, exp);
    finish_cycle();
  endtask

  task automatic read_push(input logic [7:0] exp, input logic [7:0] b, input string tag);
    @(negedge clk);
    seln = 1'b0; from_devn = 1'b0; rs = 1'b0;
    rx_strobe = 1'b1; rx_data = b;
    #1 check(tag, io_bus, exp);
    finish_cycle();
  endtask

  task automatic write_status(input logic [7:0] v, input logic do_push, input logic [7:0] b);
    @(negedge clk);
    seln = 1'b0; to_devn = 1'b0; rs = 1'b1; cpu_oe = 1'b1; cpu_drv = v;
    rx_strobe = do_push; rx_data = b;
    finish_cycle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1 check("reset_rx_full", {7'b0, rx_full}, 8'h00);
    @(negedge clk);
    seln = 1'b0; from_devn = 1'b0; rs = 1'b1;
    #1 check("reset_bus_z", io_bus, 8'hFF);
    idle();
    @(negedge clk) reset = 1'b0;

    // 1: empty device after reset
    read(1'b1, 8'h00, "t1_status");
    read(1'b0, 8'h00, "t1_data_empty");
    check("t1_rx_full", {7'b0, rx_full}, 8'h00);
    @(negedge clk);
    seln = 1'b1; from_devn = 1'b0;
    #1 check("t1_unselected_z", io_bus, 8'hFF);
    idle();

    // 2: in-order delivery
    push(8'h41); push(8'h42); push(8'h43);
    read(1'b0, 8'h41, "t2_rd0");
    read(1'b0, 8'h42, "t2_rd1");
    read(1'b1, 8'h01, "t2_status_1left");
    read(1'b0, 8'h43, "t2_rd2");
    read(1'b1, 8'h00, "t2_status_empty");

    // 3: fill, overflow, clear overflow, drain
    for (int unsigned i = 0; i < 8; i++) push(8'h10 + 8'(i));
    check("t3_rx_full", {7'b0, rx_full}, 8'h01);
    read(1'b1, 8'h03, "t3_status_full");
    push(8'h99);
    read(1'b1, 8'h07, "t3_status_ovf");
    write_status(8'h04, 1'b0, 8'h00);
    read(1'b1, 8'h03, "t3_status_clr");
    for (int unsigned i = 0; i < 8; i++) read(1'b0, 8'h10 + 8'(i), $sformatf("t3_drain%0d", i));
    read(1'b1, 8'h00, "t3_status_drained");
    check("t3_rx_full_drained", {7'b0, rx_full}, 8'h00);

    // 4: push+pop while full drops the byte, while not full keeps count
    for (int unsigned i = 0; i < 8; i++) push(8'h10 + 8'(i));
    read_push(8'h10, 8'h55, "t4_full_pp");
    read(1'b1, 8'h05, "t4_status_ovf_cnt7");
    check("t4_rx_full", {7'b0, rx_full}, 8'h00);
    write_status(8'h04, 1'b0, 8'h00);
    read_push(8'h11, 8'h66, "t4_nonfull_pp");
    read(1'b1, 8'h01, "t4_status_cnt7");
    for (int unsigned i = 0; i < 6; i++) read(1'b0, 8'h12 + 8'(i), $sformatf("t4_drain%0d", i));
    read(1'b0, 8'h66, "t4_pushed_last");
    read(1'b1, 8'h00, "t4_status_empty");

    // 5: flush wins over a concurrent push
    for (int unsigned i = 0; i < 5; i++) push(8'h01 + 8'(i));
    write_status(8'h01, 1'b1, 8'h77);
    read(1'b1, 8'h00, "t5_status_flushed");
    read(1'b0, 8'h00, "t5_data_flushed");

    // 6: reset in the middle of a DATA read
    push(8'hA1); push(8'hA2); push(8'hA3);
    @(negedge clk);
    seln = 1'b0; from_devn = 1'b0; rs = 1'b0;
    #1 check("t6_rd_before_rst", io_bus, 8'hA1);
    reset = 1'b1;
    #1 check("t6_bus_z_in_rst", io_bus, 8'hFF);
    @(posedge clk);
    #1 idle();
    @(negedge clk) reset = 1'b0;
    read(1'b1, 8'h00, "t6_status_after_rst");
    read(1'b0, 8'h00, "t6_data_after_rst");

`ifdef IO_INPUT_IRQ_EN
    check("t6_irq_idle", {7'b0, irq}, 8'h00);
    @(negedge clk);
    rx_strobe = 1'b1; rx_data = 8'h5A;
    #1 check("t6_irq_before_push_edge", {7'b0, irq}, 8'h00);
    finish_cycle();
    check("t6_irq_after_push", {7'b0, irq}, 8'h01);
    @(negedge clk);
    seln = 1'b0; from_devn = 1'b0; rs = 1'b0;
    #1 check("t6_irq_before_pop_edge", {7'b0, irq}, 8'h01);
    check("t6_irq_pop_data", io_bus, 8'h5A);
    finish_cycle();
    check("t6_irq_after_pop", {7'b0, irq}, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
